instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Fetch front end placed directly upstream of the instruction memory. It owns the program counter, drives the word address into the combinational instruction memory, and captures each returned word with its PC into a small fetch queue. Decode consumes the queue through a valid/ready handshake. The block also handles redirects from branches and jumps, and halts fetch after an `ecall`.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset. Must be word aligned.
- `QUEUE_DEPTH`, default 2: fetch queue entries. Power of two, ≥2.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `imem_addr` out 32: byte address to the instruction memory. Always equals `pc`.
- `imem_rdata` in 32: instruction word. Combinational, valid in the same cycle as `imem_addr`.
- `redirect_valid` in 1: taken branch or jump from execute.
- `redirect_pc` in 32: target address. Bits [1:0] are forced to 0.
- `out_valid` out 1: queue head holds a valid instruction.
- `out_ready` in 1: decode accepts the head this cycle.
- `out_instr` out 32: head instruction word.
- `out_pc` out 32: head PC.
- `out_pc_plus4` out 32: head PC + 4, used as the link value for JAL/JALR.
- `halted` out 1: an `ecall` has been fetched and fetch is stopped.

## Operation
- State:
  - `pc`
  - `halted` flag
  - queue of {pc, instr} entries, with read/write pointers and a count
- Fetch condition `fetch_en = !halted && (count < QUEUE_DEPTH || pop)`, where `pop = out_valid && out_ready`.
- Each cycle with `fetch_en` and no redirect:
  - push {`pc`, `imem_rdata`} into the queue;
  - `pc <= pc + 4`, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- ECALL (`imem_rdata == 32'h0000_0073`) when pushed: the entry is still enqueued, `halted <= 1`, and `pc` does not advance.
- While halted:
  - no pushes; `pc` holds;
  - the queue keeps draining to decode normally.
- Redirect (takes priority over everything):
  - queue flushed: count ← 0, pointers ← 0;
  - `pc <= {redirect_pc[31:2],2'b00}`;
  - `halted <= 0`;
  - no push that cycle;
  - a simultaneous pop is discarded, so decode must treat that cycle's handshake as squashed.
- Full queue with no pop: fetch stalls and `imem_addr` holds.
- Full queue with pop: push and pop occur in the same cycle and count is unchanged.
- Empty queue: `out_valid=0`. `out_instr`, `out_pc` and `out_pc_plus4` are don't-care but must not be X. Drive them from the storage array, which is zeroed on reset.
- Arithmetic is all 32-bit unsigned. Count width is `$clog2(QUEUE_DEPTH)+1`.

## Timing
- Reset values:
  - `pc = RESET_PC`, `imem_addr = RESET_PC`
  - `out_valid = 0`, `halted = 0`
  - `out_instr = 0`, `out_pc = 0`, `out_pc_plus4 = 4`
  - queue empty
- Latency:
  - The word addressed in cycle N is visible at the head in cycle N+1 (one register stage).
  - A redirect asserted in cycle N drives `imem_addr = target` in N+1 and makes the target instruction valid at the head in N+2.
- Throughput: 1 instruction per cycle when `out_ready` is held high.
- `rst` mid-operation overrides redirect, fetch and pop. All state returns to reset values at that edge.
- `redirect_valid` while halted restarts fetch from the target on the next cycle.

## Structure
- Shared package `rv_core_pkg`:
  - `OPC_CUSTOM0 = 7'b0001011`
  - `INSTR_ECALL = 32'h0000_0073`
  - `INSTR_NOP = 32'h0000_0013`
  - `XLEN = 32`
  - a packed struct type `fetch_entry_t` {pc, instr}
- One sub-module, `fetch_queue`:
  - synchronous FIFO of `fetch_entry_t` with push, pop, flush, full and empty;
  - same `clk`/`rst` and same parameter `QUEUE_DEPTH`.
- The top level contains the PC register, the halt flag and the control logic.

## Test plan
- Reset, then `out_ready=1`, with imem preloaded with sequential words → `out_pc` sequence 0x00, 0x04, 0x08, … on consecutive cycles, first `out_valid` one cycle after `rst` falls.
- Hold `out_ready=0` for 5 cycles → the queue fills to 2 entries, `imem_addr` freezes at 0x08, and on release entries 0x00 and 0x04 drain in order with nothing lost or duplicated.
- `redirect_valid` with `redirect_pc=0x0000_000E` while the queue is full → queue flushed, next `imem_addr=0x0C`, `out_pc=0x0C` two cycles later, and the squashed head is not re-presented.
- Word 0x0000_0073 at 0x40 → the entry is delivered with `out_pc=0x40`, `halted=1`, `imem_addr` stays 0x40 and `out_valid` drops after draining; a redirect to 0x00 clears `halted` and fetch resumes.
- Redirect to 0xFFFF_FFFC → the next fetched PC is 0x0000_0000 (wrap). `rst` asserted during a stall returns every output to its reset value on that edge.

Source files
------------

// File: rtl/rv_core_pkg.sv
// Shared core types and constants for the RV front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rv_core_pkg;

    localparam int          XLEN        = 32;
    localparam logic [6:0]  OPC_CUSTOM0 = 7'b0001011;
    localparam logic [31:0] INSTR_ECALL = 32'h0000_0073;
    localparam logic [31:0] INSTR_NOP   = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory, redirect and decode-side bundle of the fetch unit.
// Latency: n/a (wires only).
// Backpressure: out_valid/out_ready handshake toward decode.
interface instr_fetch_unit_if;

    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic        halted;

    modport master (
        output imem_addr,
        input  imem_rdata,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        output out_pc_plus4,
        output halted
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        input  out_pc_plus4,
        input  halted
    );

endinterface

// File: rtl/instr_fetch_unit_queue.sv
// Fetch queue: synchronous FIFO of {pc, instr} entries with flush.
// Latency: a pushed entry is at the head the cycle after the push.
// Backpressure: full reported to the producer; push+pop on a full queue is allowed.
module fetch_queue
    import rv_core_pkg::*;
#(
    parameter int QUEUE_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t    mem [QUEUE_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(QUEUE_DEPTH));
    assign empty = (count == '0);

    // Storage is zeroed on reset so the head never shows X while empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: owns the PC, reads combinational imem, queues {pc, instr} for decode.
// Latency: addressed word at the queue head next cycle; redirect target at the head two cycles later.
// Backpressure: stalls PC when the queue is full with no pop; halts after a fetched ecall.
module instr_fetch_unit
    import rv_core_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    instr_fetch_unit_if.master  bus
);

    logic [31:0]  pc;
    logic         halted_q;
    logic         q_full;
    logic         q_empty;
    fetch_entry_t q_head;
    fetch_entry_t push_entry;
    logic         pop;
    logic         fetch_en;
    logic         push;
    logic         is_ecall;
    logic [31:0]  redirect_target;

    assign pop             = !q_empty && bus.out_ready;
    assign fetch_en        = !halted_q && (!q_full || pop);
    assign push            = fetch_en && !bus.redirect_valid;
    assign is_ecall        = (bus.imem_rdata == INSTR_ECALL);
    assign redirect_target = bus.redirect_pc & 32'hFFFF_FFFC;
    assign push_entry      = '{pc: pc, instr: bus.imem_rdata};

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            halted_q <= 1'b0;
        end else if (bus.redirect_valid) begin
            pc       <= redirect_target;
            halted_q <= 1'b0;
        end else if (push) begin
            // An ecall is still delivered, but the PC parks on it.
            if (is_ecall) begin
                halted_q <= 1'b1;
            end else begin
                pc <= pc + 32'd4;
            end
        end
    end

    // Redirect flushes the queue, which also squashes any pop in that cycle.
    fetch_queue #(
        .QUEUE_DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (bus.redirect_valid),
        .head      (q_head),
        .full      (q_full),
        .empty     (q_empty)
    );

    assign bus.imem_addr    = pc;
    assign bus.out_valid    = !q_empty;
    assign bus.out_instr    = q_head.instr;
    assign bus.out_pc       = q_head.pc;
    assign bus.out_pc_plus4 = q_head.pc + 32'd4;
    assign bus.halted       = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: stall/drain, redirect flush, ecall halt, PC wrap, reset mid-stall.
module tb_instr_fetch_unit;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    instr_fetch_unit_if bus();

    instr_fetch_unit #(
        .RESET_PC    (32'h0000_0000),
        .QUEUE_DEPTH (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (a == 32'h0000_0040) return 32'h0000_0073;
        return 32'h1000_0000 ^ a;
    endfunction

    always_comb bus.imem_rdata = word_at(bus.imem_addr);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst                = 1'b1;
        bus.out_ready      = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        step();
        step();
        chk("rst_addr",  bus.imem_addr,    32'h0);
        chk("rst_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_halt",  32'(bus.halted),  32'h0);
        chk("rst_instr", bus.out_instr,    32'h0);
        chk("rst_pc",    bus.out_pc,       32'h0);
        chk("rst_pc4",   bus.out_pc_plus4, 32'h4);

        // Stall with out_ready low: queue fills with 0x00, 0x04 and the PC freezes at 0x08.
        rst = 1'b0;
        step();
        chk("first_valid", 32'(bus.out_valid), 32'h1);
        chk("first_pc",    bus.out_pc,    32'h0);
        chk("first_instr", bus.out_instr, 32'h1000_0000);
        step(); step(); step(); step();
        chk("stall_addr", bus.imem_addr, 32'h8);
        chk("stall_head", bus.out_pc,    32'h0);

        bus.out_ready = 1'b1;
        step();
        chk("drain_pc1",   bus.out_pc,       32'h4);
        chk("drain_pc4_1", bus.out_pc_plus4, 32'h8);
        chk("drain_addr",  bus.imem_addr,    32'hC);
        step();
        chk("drain_pc2",   bus.out_pc,    32'h8);
        chk("drain_ins2",  bus.out_instr, 32'h1000_0008);

        // Fill again, then redirect to an unaligned target while full with a squashed pop.
        bus.out_ready = 1'b0;
        step();
        chk("full_head", bus.out_pc,    32'h8);
        chk("full_addr", bus.imem_addr, 32'h10);
        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_000E;
        step();
        bus.redirect_valid = 1'b0;
        chk("redir_addr",  bus.imem_addr,      32'hC);
        chk("redir_flush", 32'(bus.out_valid), 32'h0);
        step();
        chk("redir_valid", 32'(bus.out_valid), 32'h1);
        chk("redir_pc",    bus.out_pc,         32'hC);
        step();
        chk("redir_next",  bus.out_pc,         32'h10);

        // Run into the ecall at 0x40.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0038;
        step();
        bus.redirect_valid = 1'b0;
        step();
        chk("pre_ecall0", bus.out_pc, 32'h38);
        step();
        chk("pre_ecall1", bus.out_pc, 32'h3C);
        step();
        chk("ecall_pc",    bus.out_pc,        32'h40);
        chk("ecall_instr", bus.out_instr,     32'h0000_0073);
        chk("ecall_halt",  32'(bus.halted),   32'h1);
        chk("ecall_addr",  bus.imem_addr,     32'h40);
        step();
        chk("halt_empty",  32'(bus.out_valid), 32'h0);
        chk("halt_addr",   bus.imem_addr,      32'h40);
        step();
        chk("halt_hold",   32'(bus.halted),    32'h1);
        chk("halt_noval",  32'(bus.out_valid), 32'h0);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0;
        step();
        bus.redirect_valid = 1'b0;
        chk("resume_halt", 32'(bus.halted), 32'h0);
        chk("resume_addr", bus.imem_addr,   32'h0);
        step();
        chk("resume_valid", 32'(bus.out_valid), 32'h1);
        chk("resume_pc",    bus.out_pc,         32'h0);

        // PC wrap from the top of the address space.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        step();
        bus.redirect_valid = 1'b0;
        chk("wrap_addr0", bus.imem_addr, 32'hFFFF_FFFC);
        step();
        chk("wrap_head",  bus.out_pc,       32'hFFFF_FFFC);
        chk("wrap_pc4",   bus.out_pc_plus4, 32'h0);
        chk("wrap_addr1", bus.imem_addr,    32'h0);
        step();
        chk("wrap_next",  bus.out_pc,       32'h0);

        // Reset asserted in the middle of a stall.
        bus.out_ready = 1'b0;
        step();
        step();
        chk("stall2_addr", bus.imem_addr, 32'h8);
        chk("stall2_head", bus.out_pc,    32'h0);
        rst = 1'b1;
        step();
        chk("mrst_addr",  bus.imem_addr,       32'h0);
        chk("mrst_valid", 32'(bus.out_valid),  32'h0);
        chk("mrst_halt",  32'(bus.halted),     32'h0);
        chk("mrst_instr", bus.out_instr,       32'h0);
        chk("mrst_pc",    bus.out_pc,          32'h0);
        chk("mrst_pc4",   bus.out_pc_plus4,    32'h4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
